// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine.
// Holds the FSM state encoding, the configuration address map and the
// reset-time Sobel kernels. No ports.
package conv_pkg;

    localparam int unsigned N_TAPS     = 9;
    localparam int unsigned CFG_ADDR_W = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ_FULL = 3'd1,
        S_READ_COL  = 3'd2,
        S_MUL       = 3'd3,
        S_ACC       = 3'd4,
        S_WRITE     = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    // Configuration address map: A0..A8, B0..B8, shift, mode; 20..31 unmapped.
    localparam logic [CFG_ADDR_W-1:0] CFG_A_BASE = 5'd0;
    localparam logic [CFG_ADDR_W-1:0] CFG_B_BASE = 5'd9;
    localparam logic [CFG_ADDR_W-1:0] CFG_SHIFT  = 5'd18;
    localparam logic [CFG_ADDR_W-1:0] CFG_MODE   = 5'd19;

    // Vertical Sobel kernel, raster order; loaded into A at reset.
    function automatic int sobel_v(input int idx);
        case (idx)
            0: return 1;
            1: return 0;
            2: return -1;
            3: return 2;
            4: return 0;
            5: return -2;
            6: return 1;
            7: return 0;
            default: return -1;
        endcase
    endfunction

    // Horizontal Sobel kernel, raster order; loaded into B at reset.
    function automatic int sobel_h(input int idx);
        case (idx)
            0: return 1;
            1: return 2;
            2: return 1;
            3: return 0;
            4: return 0;
            5: return 0;
            6: return -1;
            7: return -2;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/conv_engine_mac9.sv
// 9-tap multiply-accumulate: unsigned pixels times signed coefficients.
// Ports: clk, rst_n; mul_en registers the nine products; acc_en registers
// their sum; pix / coef are the nine taps packed tap 0 in the low bits;
// sum is the registered two's-complement total.
module conv_mac9
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mul_en,
    input  logic                          acc_en,
    input  logic [9*DATA_W-1:0]           pix,
    input  logic [9*COEF_W-1:0]           coef,
    output logic [DATA_W+COEF_W+4:0]      sum
);

    localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
    localparam int unsigned ACC_W  = DATA_W + COEF_W + 5;

    logic signed [PROD_W-1:0] prod [N_TAPS];
    logic signed [ACC_W-1:0]  sum_c;

    // Adder tree over sign-extended products; 9 terms cannot overflow ACC_W.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + ACC_W'(prod[i]);
        end
    end

    // Product and sum pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                prod[i] <= '0;
            end
            sum <= '0;
        end else begin
            if (mul_en) begin
                for (int i = 0; i < 9; i++) begin
                    prod[i] <= PROD_W'($signed({1'b0, pix[i*DATA_W +: DATA_W]}))
                             * PROD_W'($signed(coef[i*COEF_W +: COEF_W]));
                end
            end
            if (acc_en) begin
                sum <= sum_c;
            end
        end
    end

endmodule

// File: rtl/conv_engine.sv
// 3x3 convolution engine over an IMG_WIDTH x IMG_HEIGHT image held in bram0,
// writing one result pixel per window into bram1. Zero padding at the edges;
// column reuse when stepping right along a row.
// Ports: clk, rst_n; start/busy/done run handshake; cfg_we/cfg_addr/cfg_wdata
// coefficient, shift and mode writes (IDLE only); bram0_addr/en/dout pixel
// read port (2-cycle read latency); bram1_addr/din/we result write port.
module conv_engine
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [31:0] bram0_addr,
    output logic        bram0_en,
    input  logic [31:0] bram0_dout,
    output logic [31:0] bram1_addr,
    output logic [31:0] bram1_din,
    output logic [3:0]  bram1_we
);

    localparam int unsigned XW    = $clog2(IMG_WIDTH);
    localparam int unsigned YW    = $clog2(IMG_HEIGHT);
    localparam int unsigned ACC_W = DATA_W + COEF_W + 5;

    state_t                    state;
    logic [3:0]                cnt;
    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic [DATA_W-1:0]         win [N_TAPS];
    logic                      pad [N_TAPS];
    logic signed [COEF_W-1:0]  coef_a [N_TAPS];
    logic signed [COEF_W-1:0]  coef_b [N_TAPS];
    logic [3:0]                shift;
    logic                      mode;

    logic [9*DATA_W-1:0]       pix_flat;
    logic [9*COEF_W-1:0]       a_flat;
    logic [9*COEF_W-1:0]       b_flat;
    logic [ACC_W-1:0]          sum_a;
    logic [ACC_W-1:0]          sum_b;
    logic                      mul_en_c;
    logic                      acc_en_c;

    logic signed [ACC_W-1:0]   sa;
    logic signed [ACC_W-1:0]   sb;
    logic signed [ACC_W-1:0]   sa_sh;
    logic [ACC_W-1:0]          abs_a;
    logic [ACC_W-1:0]          abs_b;
    logic [ACC_W:0]            mag;
    logic [ACC_W:0]            mag_sh;
    logic [DATA_W-1:0]         result_c;
    logic                      last_col_c;
    logic                      last_pix_c;
    logic                      unused_bits;

    assign unused_bits = ^{bram0_dout, cfg_wdata};

    // Byte address of window tap (0..8, raster) centred on (px,py); MSB = padded.
    function automatic logic [32:0] tap_addr(input logic [XW-1:0] px,
                                             input logic [YW-1:0] py,
                                             input logic [3:0]    tap);
        int r, c, row, col;
        r   = int'(tap) / 3;
        c   = int'(tap) % 3;
        row = int'(py) + r - 1;
        col = int'(px) + c - 1;
        if (row < 0 || row >= IMG_HEIGHT || col < 0 || col >= IMG_WIDTH)
            return {1'b1, 32'd0};
        return {1'b0, 32'(row * IMG_WIDTH + col) << 2};
    endfunction

    function automatic logic [31:0] pix_addr(input logic [XW-1:0] px,
                                             input logic [YW-1:0] py);
        return 32'(int'(py) * IMG_WIDTH + int'(px)) << 2;
    endfunction

    // Window index of the right-hand column tap in row r.
    function automatic logic [3:0] col_tap(input logic [3:0] r);
        case (r)
            4'd0:    return 4'd2;
            4'd1:    return 4'd5;
            default: return 4'd8;
        endcase
    endfunction

    assign mul_en_c   = (state == S_MUL);
    assign acc_en_c   = (state == S_ACC);
    assign last_col_c = (x == XW'(IMG_WIDTH - 1));
    assign last_pix_c = last_col_c && (y == YW'(IMG_HEIGHT - 1));

    // Pack window and kernels for the MAC instances.
    always_comb begin
        pix_flat = '0;
        a_flat   = '0;
        b_flat   = '0;
        for (int i = 0; i < 9; i++) begin
            pix_flat[i*DATA_W +: DATA_W] = win[i];
            a_flat[i*COEF_W +: COEF_W]   = coef_a[i];
            b_flat[i*COEF_W +: COEF_W]   = coef_b[i];
        end
    end

    conv_mac9 #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_en (mul_en_c),
        .acc_en (acc_en_c),
        .pix    (pix_flat),
        .coef   (a_flat),
        .sum    (sum_a)
    );

    conv_mac9 #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_en (mul_en_c),
        .acc_en (acc_en_c),
        .pix    (pix_flat),
        .coef   (b_flat),
        .sum    (sum_b)
    );

    // Post-processing: mode 0 = clamped shifted sumA, mode 1 = saturated |A|+|B|.
    always_comb begin
        sa       = $signed(sum_a);
        sb       = $signed(sum_b);
        sa_sh    = sa >>> shift;
        abs_a    = sa[ACC_W-1] ? ACC_W'(-sa) : ACC_W'(sa);
        abs_b    = sb[ACC_W-1] ? ACC_W'(-sb) : ACC_W'(sb);
        mag      = {1'b0, abs_a} + {1'b0, abs_b};
        mag_sh   = mag >> shift;
        result_c = '0;
        if (!mode) begin
            if (sa_sh[ACC_W-1])
                result_c = '0;
            else if (|sa_sh[ACC_W-2:DATA_W])
                result_c = '1;
            else
                result_c = sa_sh[DATA_W-1:0];
        end else begin
            if (|mag_sh[ACC_W:DATA_W])
                result_c = '1;
            else
                result_c = mag_sh[DATA_W-1:0];
        end
    end

    // Control FSM, read sequencing, window, configuration and write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram0_addr <= '0;
            bram0_en   <= 1'b0;
            bram1_addr <= '0;
            bram1_din  <= '0;
            bram1_we   <= '0;
            shift      <= '0;
            mode       <= 1'b1;
            for (int i = 0; i < 9; i++) begin
                win[i]    <= '0;
                pad[i]    <= 1'b0;
                coef_a[i] <= COEF_W'(sobel_v(i));
                coef_b[i] <= COEF_W'(sobel_h(i));
            end
        end else begin
            bram1_we  <= 4'h0;
            bram1_din <= '0;
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        if (cfg_addr < CFG_B_BASE)
                            coef_a[4'(cfg_addr - CFG_A_BASE)] <= cfg_wdata[COEF_W-1:0];
                        else if (cfg_addr < CFG_SHIFT)
                            coef_b[4'(cfg_addr - CFG_B_BASE)] <= cfg_wdata[COEF_W-1:0];
                        else if (cfg_addr == CFG_SHIFT)
                            shift <= cfg_wdata[3:0];
                        else if (cfg_addr == CFG_MODE)
                            mode <= cfg_wdata[0];
                    end
                    if (start) begin
                        state    <= S_READ_FULL;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bram0_en <= 1'b1;
                        {pad[0], bram0_addr} <= tap_addr(x, y, 4'd0);
                    end
                end

                // Addresses issued in cycles 0..8; data lands two cycles later.
                S_READ_FULL: begin
                    cnt <= cnt + 4'd1;
                    if (cnt < 4'd8)
                        {pad[cnt + 4'd1], bram0_addr} <= tap_addr(x, y, cnt + 4'd1);
                    else
                        bram0_addr <= '0;
                    if (cnt >= 4'd2)
                        win[cnt - 4'd2] <= pad[cnt - 4'd2] ? '0 : bram0_dout[DATA_W-1:0];
                    if (cnt == 4'd10) begin
                        state    <= S_MUL;
                        bram0_en <= 1'b0;
                    end
                end

                // Only the new right-hand column is fetched.
                S_READ_COL: begin
                    cnt <= cnt + 4'd1;
                    if (cnt < 4'd2)
                        {pad[col_tap(cnt + 4'd1)], bram0_addr} <=
                            tap_addr(x, y, col_tap(cnt + 4'd1));
                    else
                        bram0_addr <= '0;
                    if (cnt >= 4'd2)
                        win[col_tap(cnt - 4'd2)] <=
                            pad[col_tap(cnt - 4'd2)] ? '0 : bram0_dout[DATA_W-1:0];
                    if (cnt == 4'd4) begin
                        state    <= S_MUL;
                        bram0_en <= 1'b0;
                    end
                end

                S_MUL: state <= S_ACC;

                S_ACC: state <= S_WRITE;

                S_WRITE: begin
                    bram1_we   <= 4'hF;
                    bram1_din  <= 32'(result_c);
                    bram1_addr <= pix_addr(x, y);
                    for (int r = 0; r < 3; r++) begin
                        win[r*3]     <= win[r*3 + 1];
                        win[r*3 + 1] <= win[r*3 + 2];
                        win[r*3 + 2] <= '0;
                    end
                    cnt <= '0;
                    if (last_pix_c) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        x     <= '0;
                        y     <= '0;
                    end else if (last_col_c) begin
                        state    <= S_READ_FULL;
                        x        <= '0;
                        y        <= y + YW'(1);
                        bram0_en <= 1'b1;
                        {pad[0], bram0_addr} <= tap_addr('0, y + YW'(1), 4'd0);
                    end else begin
                        state    <= S_READ_COL;
                        x        <= x + XW'(1);
                        bram0_en <= 1'b1;
                        {pad[2], bram0_addr} <= tap_addr(x + XW'(1), y, 4'd2);
                    end
                end

                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine on a 4x4 image with a 2-cycle-latency
// pixel memory and a behavioural 3x3 convolution reference.
module tb_conv_engine;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [31:0] bram0_addr;
    logic        bram0_en;
    logic [31:0] bram0_dout;
    logic [31:0] bram1_addr;
    logic [31:0] bram1_din;
    logic [3:0]  bram1_we;

    always #5 clk = ~clk;

    conv_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8), .COEF_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .bram0_addr (bram0_addr),
        .bram0_en   (bram0_en),
        .bram0_dout (bram0_dout),
        .bram1_addr (bram1_addr),
        .bram1_din  (bram1_din),
        .bram1_we   (bram1_we)
    );

    // Pixel memory with two-cycle read latency; upper bits carry noise.
    logic [31:0] mem [NPIX];
    logic [31:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe    <= mem[bram0_addr[5:2]];
        bram0_dout <= rd_pipe;
    end

    int img [NPIX];
    int ca [9];
    int cb [9];
    int rshift;
    int rmode;
    int out_img [NPIX];
    int wr_count;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result-port monitor.
    always @(negedge clk) begin
        if (bram1_we !== 4'h0) begin
            wr_count++;
            chk("we_mask", 32'(bram1_we), 32'hF);
            chk("din_upper_zero", bram1_din >> 8, 32'd0);
            if (bram1_addr < 32'd64 && bram1_addr[1:0] == 2'b00)
                out_img[bram1_addr[5:2]] = int'(bram1_din[7:0]);
            else
                chk("wr_addr_range", bram1_addr, 32'd0);
        end
    end

    // Reference: direct 3x3 sum with zero padding, then the mode rule.
    function automatic int ref_pix(input int px, input int py);
        int sa, sb, v, row, col, t;
        sa = 0;
        sb = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                row = py + r - 1;
                col = px + c - 1;
                v = (row >= 0 && row < H && col >= 0 && col < W) ? img[row*W + col] : 0;
                sa += v * ca[r*3 + c];
                sb += v * cb[r*3 + c];
            end
        end
        if (rmode == 0) begin
            t = sa >>> rshift;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
        end else begin
            t = ((sa < 0 ? -sa : sa) + (sb < 0 ? -sb : sb)) >> rshift;
            if (t > 255) t = 255;
        end
        return t;
    endfunction

    task automatic set_defaults();
        ca = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        cb = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        rshift = 0;
        rmode  = 1;
    endtask

    task automatic set_cfg(input int addr, input int data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(addr);
        cfg_wdata = 16'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Coefficient write; the model keeps the sign-extended low 8 bits.
    task automatic write_coef(input bit is_b, input int idx, input int raw);
        logic [7:0] lo;
        lo = 8'(raw);
        if (is_b) cb[idx] = int'($signed(lo));
        else      ca[idx] = int'($signed(lo));
        set_cfg(is_b ? 9 + idx : idx, raw);
    endtask

    task automatic write_shift_mode(input int raw_shift, input int raw_mode);
        rshift = raw_shift & 15;
        rmode  = raw_mode & 1;
        set_cfg(18, raw_shift);
        set_cfg(19, raw_mode);
    endtask

    // kind 0: constant val, 1: ramp 0..15, 2: random.
    task automatic fill_img(input int kind, input int val);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       img[i] = val;
                1:       img[i] = i;
                default: img[i] = int'($urandom_range(0, 255));
            endcase
            mem[i] = ($urandom() & 32'hFFFF_FF00) | 32'(img[i]);
        end
    endtask

    // Start a frame (start held) and return at the first cycle done is seen.
    task automatic run_frame(input bit busy_cfg, output int en_to_done, output int en_cycles);
        int first;
        int ok;
        first      = -1;
        ok         = 0;
        en_cycles  = 0;
        en_to_done = -1;
        for (int i = 0; i < NPIX; i++) out_img[i] = -1;
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (busy_cfg && k == 20) begin
                cfg_we    = 1'b1;
                cfg_addr  = 5'd19;
                cfg_wdata = 16'(1 - rmode);
            end
            if (busy_cfg && k == 21) cfg_we = 1'b0;
            if (bram0_en) begin
                en_cycles++;
                if (first < 0) first = k;
            end
            if (done) begin
                en_to_done = k - first;
                ok = 1;
                break;
            end
        end
        cfg_we = 1'b0;
        chk("frame_done_reached", 32'(ok), 32'd1);
    endtask

    task automatic finish_frame();
        repeat (3) begin
            @(negedge clk);
            chk("done_held_with_start", 32'(done), 32'd1);
        end
        chk("busy_low_in_done", 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("done_drops_after_start", 32'(done), 32'd0);
    endtask

    task automatic check_image(input string tag);
        chk({tag, "_write_count"}, 32'(wr_count), 32'(NPIX));
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("%s_pix_x%0d_y%0d", tag, i % W, i / W),
                32'(out_img[i]), 32'(ref_pix(i % W, i / W)));
    endtask

    initial begin
        int t_done;
        int n_en;
        int reached;
        int base;

        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        wr_count  = 0;
        for (int i = 0; i < NPIX; i++) mem[i] = '0;
        set_defaults();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bram0_en", 32'(bram0_en), 32'd0);
        chk("rst_bram0_addr", bram0_addr, 32'd0);
        chk("rst_bram1_we", 32'(bram1_we), 32'd0);
        chk("rst_bram1_din", bram1_din, 32'd0);
        chk("rst_bram1_addr", bram1_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Default Sobel, constant 100; a mode write during busy must be dropped.
        fill_img(0, 100);
        run_frame(1'b1, t_done, n_en);
        chk("timing_readfull_to_done", 32'(t_done), 32'd152);
        chk("timing_bram0_en_cycles", 32'(n_en), 32'd104);
        finish_frame();
        check_image("sobel100");
        chk("sobel100_corner", 32'(out_img[0]), 32'd255);
        chk("sobel100_edge", 32'(out_img[1]), 32'd255);
        chk("sobel100_int11", 32'(out_img[5]), 32'd0);
        chk("sobel100_int22", 32'(out_img[10]), 32'd0);

        // Identity kernel on a ramp.
        for (int i = 0; i < 9; i++) write_coef(1'b0, i, (i == 4) ? 1 : 0);
        write_shift_mode(0, 0);
        fill_img(1, 0);
        run_frame(1'b0, t_done, n_en);
        finish_frame();
        check_image("identity");
        for (int i = 0; i < NPIX; i++)
            chk("identity_equals_input", 32'(out_img[i]), 32'(i));

        // Box filter, shift 3, constant 80.
        for (int i = 0; i < 9; i++) write_coef(1'b0, i, 1);
        write_shift_mode(3, 0);
        fill_img(0, 80);
        run_frame(1'b0, t_done, n_en);
        finish_frame();
        check_image("box80");
        chk("box80_interior", 32'(out_img[5]), 32'd90);
        chk("box80_corner", 32'(out_img[0]), 32'd40);

        // Negative kernel clamps to zero.
        for (int i = 0; i < 9; i++) write_coef(1'b0, i, 16'hFFFF);
        write_shift_mode(0, 0);
        fill_img(0, 50);
        run_frame(1'b0, t_done, n_en);
        finish_frame();
        check_image("negclamp");
        for (int i = 0; i < NPIX; i++)
            chk("negclamp_zero", 32'(out_img[i]), 32'd0);

        // Random kernels, shift, mode and images; unmapped cfg writes ignored.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) write_coef(1'b0, i, int'($urandom_range(0, 65535)));
            for (int i = 0; i < 9; i++) write_coef(1'b1, i, int'($urandom_range(0, 65535)));
            write_shift_mode(int'($urandom_range(0, 65535)) & ((f < 2) ? 32'h3 : 32'hFFFF),
                             (f == 0) ? 0 : (f == 1) ? 1 : int'($urandom_range(0, 65535)));
            set_cfg(int'($urandom_range(20, 31)), int'($urandom_range(0, 65535)));
            fill_img(2, 0);
            run_frame(1'b0, t_done, n_en);
            chk("rand_timing", 32'(t_done), 32'd152);
            finish_frame();
            check_image($sformatf("rand%0d", f));
        end

        // Reset during pixel (2,1): no further writes, defaults restored.
        write_shift_mode(2, 0);
        fill_img(0, 100);
        for (int i = 0; i < NPIX; i++) out_img[i] = -1;
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (wr_count >= 6) begin
                reached = 1;
                break;
            end
        end
        chk("midframe_reached_pixel_2_1", 32'(reached), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midframe_rst_busy", 32'(busy), 32'd0);
        chk("midframe_rst_we", 32'(bram1_we), 32'd0);
        base = wr_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("midframe_no_more_writes", 32'(wr_count - base), 32'd0);
        chk("midframe_idle_busy", 32'(busy), 32'd0);
        chk("midframe_idle_done", 32'(done), 32'd0);
        chk("midframe_writes_before_reset", 32'(base), 32'd6);

        set_defaults();
        fill_img(0, 100);
        run_frame(1'b0, t_done, n_en);
        chk("restart_timing", 32'(t_done), 32'd152);
        finish_frame();
        check_image("restart");
        chk("restart_corner", 32'(out_img[0]), 32'd255);
        chk("restart_edge", 32'(out_img[1]), 32'd255);
        chk("restart_int11", 32'(out_img[5]), 32'd0);
        chk("restart_int22", 32'(out_img[10]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 32, meaning image width in pixels (≥4).
REQ-002 SHALL have parameter IMG_HEIGHT, default 32, meaning image height in pixels (≥4).
REQ-003 SHALL have parameter DATA_W, default 8, meaning unsigned pixel width (1..16).
REQ-004 SHALL have parameter COEF_W, default 8, meaning signed kernel coefficient width (2..12).
REQ-005 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset, asynchronous, active-low).
REQ-006 SHALL have ports start (in, 1, run request), busy (out, 1, high outside IDLE/DONE) and done (out, 1, high in DONE).
REQ-007 SHALL have ports cfg_we (in, 1), cfg_addr (in, 5) and cfg_wdata (in, 16), forming the configuration write port.
REQ-008 SHALL have ports bram0_addr (out, 32, byte address), bram0_en (out, 1) and bram0_dout (in, 32, pixel in bits [DATA_W-1:0]).
REQ-009 SHALL have ports bram1_addr (out, 32), bram1_din (out, 32) and bram1_we (out, 4).

Function
REQ-010 SHALL hold coefficient registers A0..A8 (cfg_addr 0-8), B0..B8 (9-17), shift (18, 4 bits) and mode (19, 1 bit); each takes the low bits of cfg_wdata.
REQ-011 SHALL accept a cfg write only in IDLE; a write in any other state, or to addr 20-31, SHALL be ignored.
REQ-012 SHALL use these states: IDLE, READ_FULL, READ_COL, MUL, ACC, WRITE, DONE.
REQ-013 IDLE->READ_FULL SHALL occur on start; start in any other state SHALL be ignored.
REQ-014 READ_FULL SHALL last exactly 11 cycles (9 reads, raster order in the 3x3 window), then go to MUL.
REQ-015 READ_COL SHALL last exactly 5 cycles (3 reads, right column top to bottom), then go to MUL.
REQ-016 MUL->ACC->WRITE SHALL each take 1 cycle.
REQ-017 After WRITE the block SHALL go to DONE if the pixel was (IMG_WIDTH-1, IMG_HEIGHT-1), to READ_FULL if the next x is 0, and to READ_COL otherwise.
REQ-018 DONE SHALL stay while start is high and go to IDLE when start is low.
REQ-019 bram0_en SHALL be high exactly in READ_FULL/READ_COL; bram0_addr SHALL be registered; bram0_dout SHALL be sampled two cycles after the address cycle.
REQ-020 Address SHALL be ((row*IMG_WIDTH+col)<<2); an out-of-image tap SHALL drive address 0 and load 0 into the window (zero padding).
REQ-021 On WRITE the window SHALL shift left one column (column reuse).
REQ-022 Products SHALL be unsigned pixel x signed coefficient, width DATA_W+COEF_W+1; the 9-term sum SHALL be width ACC_W=DATA_W+COEF_W+5, with no overflow possible.
REQ-023 mode 0: result SHALL be sumA arithmetically shifted right by shift, clamped to [0, 2^DATA_W-1].
REQ-024 mode 1: result SHALL be (|sumA|+|sumB|) logically shifted right by shift, saturated to 2^DATA_W-1.
REQ-025 The cycle after WRITE, bram1_we SHALL be 4'hF for one cycle, bram1_addr SHALL be ((y*IMG_WIDTH+x)<<2), and bram1_din SHALL be the zero-extended result; otherwise bram1_we=0 and bram1_din=0.
REQ-026 Per-pixel time SHALL be 14 cycles for x=0 and 8 cycles otherwise.

Reset
REQ-027 Reset SHALL set state=IDLE, x=y=0, window=0, all bram outputs=0, busy=0 and done=0.
REQ-028 Reset SHALL load A = vertical Sobel {1,0,-1,2,0,-2,1,0,-1}, B = horizontal Sobel {1,2,1,0,0,0,-1,-2,-1}, shift=0 and mode=1.
REQ-029 Reset asserted mid-frame SHALL abort immediately with no further bram1 write; the next start SHALL begin at (0,0).

Structure
REQ-030 Package conv_pkg SHALL hold the state encoding, cfg address map constants and default Sobel coefficients.
REQ-031 Sub-module conv_mac9 (9-tap MAC, registered products and registered sum, parametrised DATA_W/COEF_W) SHALL be instantiated twice (A and B).

Verification
REQ-032 Defaults, 4x4 constant 100 -> (0,0)=255, (1,0)=255, (1,1)/(2,2)=0, 16 writes total.
REQ-033 Mode 0, A4=1 and others 0, shift 0, 4x4 ramp 0..15 -> output equals input at every pixel.
REQ-034 Mode 0, all A=1, shift 3, constant 80 -> interior=90, corner (0,0)=40.
REQ-035 Mode 0, all A=-1, constant 50 -> every output 0 (negative clamp).
REQ-036 4x4 run timing -> DONE entered exactly 152 cycles after the first READ_FULL cycle; a cfg write during busy leaves coefficients unchanged; start held -> done stays high until start drops.
REQ-037 rst_n pulsed during pixel (2,1) -> no further bram1_we, coefficients restored to defaults, and a restarted run matches REQ-032.
